struct_frame_packer: RTL and testbench
======================================

# struct_frame_packer

Byte-stream to packed-struct assembler, the producer stage for logic that consumes packed records of the form `{bit [N_ELEM-1:0][7:0] a; bit [15:0] b;}`. It accepts a big-endian byte stream with valid/ready/last framing and fills the struct fields by packed-array element index. It presents each complete record on a registered valid/ready output and flags short and long frames.

## Interface
Parameters:
- `N_ELEM`, default 8: number of byte elements in field `a`. Frame length is `N_ELEM+2` bytes. Legal range is 1..16.

Ports:
- `clk`, in, 1: single clock. All state updates on the rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `in_valid`, in, 1: byte available.
- `in_data`, in, 8: byte value.
- `in_last`, in, 1: this byte ends the frame.
- `in_ready`, out, 1: byte accepted when `in_valid && in_ready`.
- `out_valid`, out, 1: `out_frame` holds a complete record.
- `out_frame`, out, `8*N_ELEM+16`: packed struct. `a` occupies the MSBs and `b` the 16 LSBs.
- `out_ready`, in, 1: record consumed when `out_valid && out_ready`.
- `err_short`, out, 1: one-cycle pulse when a frame ends early.
- `err_long`, out, 1: one-cycle pulse when an overlong frame's last byte is dropped.

## Operation
- States are `COLLECT`, `HOLD` and `DISCARD`. Reset enters `COLLECT` with byte counter `cnt=0`.
- Byte mapping in `COLLECT`: accepted byte `k` (0-based) writes as follows.
  - k < N_ELEM: writes `a[N_ELEM-1-k]`.
  - k = N_ELEM: writes `b[15:8]`.
  - k = N_ELEM+1: writes `b[7:0]`.
  - Each write touches only its own 8 bits. Other bits keep their value.
- `COLLECT` transitions on each accepted byte:
  - `in_last` with k < N_ELEM+1: short frame. Pulse `err_short` the next cycle, set `cnt=0`, stay in `COLLECT`. `out_frame` contents are undefined-but-stable, and `out_valid` stays 0.
  - k = N_ELEM+1 with `in_last`: go to `HOLD` and set `cnt=0`.
  - k = N_ELEM+1 without `in_last`: go to `DISCARD` and set `cnt=0`. The record is not emitted.
  - Otherwise: `cnt++`.
- `HOLD`: `out_valid=1` and `out_frame` is stable. When `out_valid && out_ready`, go to `COLLECT`.
- `DISCARD`: accepts and drops bytes. The byte with `in_last` pulses `err_long` the next cycle and returns to `COLLECT`.
- `in_ready` is 1 in `COLLECT` and `DISCARD`, and 0 in `HOLD`.
- `cnt` width is `$clog2(N_ELEM+2)`. It never exceeds `N_ELEM+1`.
- Reset values: `out_valid=0`, `out_frame='0`, `in_ready=1` once `rst_n` is high, `err_short=0`, `err_long=0`.
- When `rst_n` is asserted mid-frame, a partial frame is lost. No error pulse is produced.

## Timing
- `in_ready` is a registered-state decode and has no combinational path from `out_ready`.
- `out_valid` rises in the cycle after the final byte is accepted (latency 1).
- After the output handshake, `in_ready` returns to 1 in the next cycle. Peak throughput is one record per `N_ELEM+3` cycles.
- `out_frame` must not change while `out_valid=1`.
- Once `out_valid` is asserted, it is held until the handshake completes, regardless of `in_valid`.
- Error pulses are exactly one cycle wide and registered. They never coincide with `out_valid` rising for the same frame.
- `in_valid` low in any state causes no state change. Gaps between bytes are unlimited.

## Structure
- Package `struct_frame_pkg` holds:
  - `typedef enum logic [1:0] {COLLECT, HOLD, DISCARD} pack_state_t`
  - `typedef logic [7:0] byte_t`
  - `localparam int B_BYTES = 2`
- The record struct type is declared inside the module, because it depends on `N_ELEM`.
- The block is a single module with no sub-module. The field writes use packed-array element indexing on the struct member, not flat bit slicing.

## Test plan
- Nominal: bytes FC 00 42 00 00 12 34 00 FF FC, last on FC (10th byte), `out_ready=1`. Required: `out_frame == 80'hFC00_4200_0012_3400_FFFC` one cycle after the last byte, `out_valid` high for 1 cycle.
- Backpressure: same frame with `out_ready=0` for 5 cycles. Required: `out_valid` held, `out_frame` stable, `in_ready=0` throughout. Accepted on the first `out_ready=1`, then `in_ready=1` the next cycle.
- Short frame: 4 bytes with last on the 4th. Required: `err_short` pulses once and `out_valid` stays 0. The following nominal frame outputs correctly.
- Long frame: 13 bytes with last on the 13th. Required: no `out_valid`, `err_long` pulses once after byte 13, and the next frame is correct.
- Reset mid-frame: drop `rst_n` after 5 bytes. Required: all outputs return to reset values asynchronously. A fresh 10-byte frame after release outputs correctly.
- `N_ELEM=1`: bytes 42 12 34 with last on the 3rd. Required: `out_frame == 24'h42_1234`.

Source files
------------

// File: rtl/struct_frame_pkg.sv
// Shared types for the byte-stream to packed-record assembler.
package struct_frame_pkg;

  typedef enum logic [1:0] {COLLECT, HOLD, DISCARD} pack_state_t;

  typedef logic [7:0] byte_t;

  localparam int B_BYTES = 2;

endpackage

// File: rtl/struct_frame_packer.sv
// Assembles a big-endian byte stream into {a[N_ELEM-1:0][7:0], b[15:0]} records,
// holding each record on a valid/ready output and flagging short/long frames.
module struct_frame_packer
  import struct_frame_pkg::*;
#(
  parameter int N_ELEM = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  input  logic [7:0]                in_data,
  input  logic                      in_last,
  output logic                      in_ready,
  output logic                      out_valid,
  output logic [8*N_ELEM+15:0]      out_frame,
  input  logic                      out_ready,
  output logic                      err_short,
  output logic                      err_long
);

  localparam int CW = $clog2(N_ELEM + 2);
  localparam logic [CW-1:0] B_HI_K = CW'(N_ELEM);
  localparam logic [CW-1:0] LAST_K = CW'(N_ELEM + 1);

  typedef struct packed {
    byte_t [N_ELEM-1:0]     a;
    logic  [8*B_BYTES-1:0]  b;
  } rec_t;

  pack_state_t   state_q;
  logic [CW-1:0] cnt_q;
  rec_t          rec_q;
  logic          err_short_q;
  logic          err_long_q;
  logic          accept_s;

  assign in_ready  = (state_q != HOLD);
  assign out_valid = (state_q == HOLD);
  assign out_frame = rec_q;
  assign err_short = err_short_q;
  assign err_long  = err_long_q;
  assign accept_s  = in_valid && in_ready;

  // Frame FSM: byte placement, record hold and error pulse generation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= COLLECT;
      cnt_q       <= '0;
      rec_q       <= '0;
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
    end else begin
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
      case (state_q)
        COLLECT: begin
          if (accept_s) begin
            // Byte k lands in a[N_ELEM-1-k]: first byte on the wire is the MSB element.
            for (int i = 0; i < N_ELEM; i++) begin
              if (cnt_q == CW'(N_ELEM - 1 - i)) begin
                rec_q.a[i] <= in_data;
              end
            end
            if (cnt_q == B_HI_K) begin
              rec_q.b[15:8] <= in_data;
            end
            if (cnt_q == LAST_K) begin
              rec_q.b[7:0] <= in_data;
            end
            if (cnt_q == LAST_K) begin
              cnt_q   <= '0;
              state_q <= in_last ? HOLD : DISCARD;
            end else if (in_last) begin
              cnt_q       <= '0;
              err_short_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_q <= COLLECT;
          end
        end
        DISCARD: begin
          if (accept_s && in_last) begin
            err_long_q <= 1'b1;
            state_q    <= COLLECT;
          end
        end
        default: begin
          state_q <= COLLECT;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_struct_frame_packer.sv
// Directed, table-driven bench for struct_frame_packer (N_ELEM=8 and N_ELEM=1).
module tb_struct_frame_packer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_last, out_ready;
  logic [7:0]  in_data;
  logic        in_ready, out_valid, err_short, err_long;
  logic [79:0] out_frame;

  logic        in_valid1, in_last1, out_ready1;
  logic [7:0]  in_data1;
  logic        in_ready1, out_valid1, err_short1, err_long1;
  logic [23:0] out_frame1;

  always #5 clk = ~clk;

  struct_frame_packer #(.N_ELEM(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .out_valid(out_valid), .out_frame(out_frame), .out_ready(out_ready),
    .err_short(err_short), .err_long(err_long)
  );

  struct_frame_packer #(.N_ELEM(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_data(in_data1), .in_last(in_last1),
    .in_ready(in_ready1), .out_valid(out_valid1), .out_frame(out_frame1), .out_ready(out_ready1),
    .err_short(err_short1), .err_long(err_long1)
  );

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        l;
    logic        r;
    logic        eir;
    logic        eov;
    logic        es;
    logic        el;
    logic        cf;
    logic [79:0] ef;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int errors = 0;

  logic [7:0]  nom [10] = '{8'hFC, 8'h00, 8'h42, 8'h00, 8'h00, 8'h12, 8'h34, 8'h00, 8'hFF, 8'hFC};
  logic [7:0]  bp  [10] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'hA5, 8'h5A};
  logic [7:0]  alt [10] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'hA8, 8'hA9};
  logic [79:0] exp_nom = 80'hFC00_4200_0012_3400_FFFC;
  logic [79:0] exp_bp  = 80'h0102_0304_0506_0708_A55A;
  logic [79:0] exp_alt = 80'hA0A1_A2A3_A4A5_A6A7_A8A9;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic v, input logic [7:0] d, input logic l, input logic r,
                     input logic eir, input logic eov, input logic es, input logic el,
                     input logic cf, input logic [79:0] ef);
    vec_t x;
    x.v = v; x.d = d; x.l = l; x.r = r;
    x.eir = eir; x.eov = eov; x.es = es; x.el = el; x.cf = cf; x.ef = ef;
    vecs.push_back(x);
  endtask

  // Ten bytes, last on the tenth; record expected one cycle after the final byte.
  task automatic add_frame(input logic [7:0] b [10], input logic [79:0] ef);
    for (int k = 0; k < 9; k++) begin
      add(1'b1, b[k], 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 80'h0);
    end
    add(1'b1, b[9], 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, ef);
  endtask

  task automatic run_vecs(input string tag);
    foreach (vecs[i]) begin
      in_valid  = vecs[i].v;
      in_data   = vecs[i].d;
      in_last   = vecs[i].l;
      out_ready = vecs[i].r;
      @(posedge clk);
      #1;
      chk($sformatf("%s[%0d] in_ready", tag, i), {79'h0, in_ready}, {79'h0, vecs[i].eir});
      chk($sformatf("%s[%0d] out_valid", tag, i), {79'h0, out_valid}, {79'h0, vecs[i].eov});
      chk($sformatf("%s[%0d] err_short", tag, i), {79'h0, err_short}, {79'h0, vecs[i].es});
      chk($sformatf("%s[%0d] err_long", tag, i), {79'h0, err_long}, {79'h0, vecs[i].el});
      if (vecs[i].cf) begin
        chk($sformatf("%s[%0d] out_frame", tag, i), out_frame, vecs[i].ef);
      end
    end
    vecs.delete();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic step1(input logic v, input logic [7:0] d, input logic l, input logic r);
    in_valid1 = v; in_data1 = d; in_last1 = l; out_ready1 = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; out_ready = 1'b0;
    in_valid1 = 1'b0; in_data1 = 8'h00; in_last1 = 1'b0; out_ready1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst out_valid", {79'h0, out_valid}, 80'h0);
    chk("rst out_frame", out_frame, 80'h0);
    chk("rst err_short", {79'h0, err_short}, 80'h0);
    chk("rst err_long", {79'h0, err_long}, 80'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst in_ready", {79'h0, in_ready}, 80'h1);

    // Nominal frame followed by an immediate handshake.
    add_frame(nom, exp_nom);
    add(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, exp_nom);
    // Backpressure: five stalled cycles with in_valid high, then accept.
    add_frame(bp, exp_bp);
    for (int k = 0; k < 5; k++) begin
      add(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, exp_bp);
    end
    add(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, exp_bp);
    // Short frame with an idle gap carrying a stray in_last.
    add(1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 80'h0);
    add(1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 80'h0);
    add(1'b0, 8'h99, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 80'h0);
    add(1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 80'h0);
    add(1'b1, 8'h44, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 80'h0);
    add(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 80'h0);
    add_frame(nom, exp_nom);
    add(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, exp_nom);
    // Long frame: 13 bytes, gap inside the discard phase.
    for (int k = 0; k < 12; k++) begin
      add(1'b1, 8'h30 + 8'(k), 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 80'h0);
      if (k == 10) begin
        add(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 80'h0);
      end
    end
    add(1'b1, 8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 80'h0);
    add(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 80'h0);
    add_frame(alt, exp_alt);
    add(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, exp_alt);
    run_vecs("main");

    // Reset mid-frame after five bytes.
    for (int k = 0; k < 5; k++) begin
      add(1'b1, nom[k], 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 80'h0);
    end
    run_vecs("pre_rst");
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst out_valid", {79'h0, out_valid}, 80'h0);
    chk("mid_rst out_frame", out_frame, 80'h0);
    chk("mid_rst in_ready", {79'h0, in_ready}, 80'h1);
    chk("mid_rst err_short", {79'h0, err_short}, 80'h0);
    chk("mid_rst err_long", {79'h0, err_long}, 80'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    add_frame(nom, exp_nom);
    add(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, exp_nom);
    run_vecs("post_rst");

    // N_ELEM=1 instance: nominal record, handshake, then a short frame.
    step1(1'b1, 8'h42, 1'b0, 1'b1);
    chk("n1 mid out_valid", {79'h0, out_valid1}, 80'h0);
    step1(1'b1, 8'h12, 1'b0, 1'b1);
    step1(1'b1, 8'h34, 1'b1, 1'b1);
    chk("n1 out_valid", {79'h0, out_valid1}, 80'h1);
    chk("n1 out_frame", {56'h0, out_frame1}, 80'h42_1234);
    chk("n1 in_ready hold", {79'h0, in_ready1}, 80'h0);
    step1(1'b0, 8'h00, 1'b0, 1'b1);
    chk("n1 handshake out_valid", {79'h0, out_valid1}, 80'h0);
    chk("n1 handshake in_ready", {79'h0, in_ready1}, 80'h1);
    step1(1'b1, 8'h77, 1'b0, 1'b1);
    step1(1'b1, 8'h88, 1'b1, 1'b1);
    chk("n1 short err_short", {79'h0, err_short1}, 80'h1);
    chk("n1 short out_valid", {79'h0, out_valid1}, 80'h0);
    step1(1'b0, 8'h00, 1'b0, 1'b1);
    chk("n1 short pulse end", {79'h0, err_short1}, 80'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
